cardinal_nic: RTL and testbench
===============================

# cardinal_nic

Network interface controller between one `cardinal_processor` and its ring router port. It owns a one-entry input channel buffer and a one-entry output channel buffer, each with a full/empty status bit. The processor reaches it through the 2-bit NIC register window (`addr_nic`, `din_nic`, `dout_nic`, `nicEn`, `nicWrEn`). It sequences packet injection and ejection with the router over a send/ready handshake gated by ring polarity.

## Interface
- `DATA_W`, 64: packet and register data width, big-endian `[0:DATA_W-1]`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `addr`  in  2  register select, driven from processor `addr_nic`.
- `d_in`  in  64  write data from processor `din_nic`.
- `d_out`  out  64  read data to processor `dout_nic`; registered.
- `nicEn`  in  1  register access strobe.
- `nicWrEn`  in  1  1 = write, 0 = read; qualified by `nicEn`.
- `net_si`  in  1  router offers a packet to the NIC.
- `net_ri`  out  1  NIC can accept a packet (input buffer empty).
- `net_di`  in  64  packet from router.
- `net_so`  out  1  NIC presents a packet to the router; registered one-cycle pulse.
- `net_ro`  in  1  router can accept a packet this cycle.
- `net_do`  out  64  packet to router; registered, valid while `net_so`=1.
- `net_polarity`  in  1  router even/odd cycle phase.

## Operation
- Address map:
  - 00: input buffer. Read only.
  - 01: input status. Read only; bit 63 = `in_full`, bits 0-62 = 0.
  - 10: output buffer. Write only.
  - 11: output status. Read only; bit 63 = `out_full`, bits 0-62 = 0.
- Register access rules:
  - Writes to 00, 01 and 11 are ignored.
  - Reads of 10 return all zeros.
- Ejection (router to NIC):
  - `net_ri = ~in_full`, combinational.
  - On an edge with `net_si & net_ri`: `ibuf <= net_di` and `in_full <= 1`.
  - `net_si` while `in_full` = 1 is ignored; the router must hold off.
- Processor read of 00 (`nicEn=1`, `nicWrEn=0`, `addr=00`): `d_out <= ibuf` and `in_full <= 0` on the same edge.
- A read of 00 while empty returns stale `ibuf` and does not change status.
- Processor write of 10:
  - If `out_full` = 0: `obuf <= d_in` and `out_full <= 1`.
  - If `out_full` = 1: the write is dropped silently. Software polls 11 first.
- Injection (NIC to router), on an edge where `out_full & net_ro & (obuf[0] == net_polarity)`:
  - `net_so <= 1`, `net_do <= obuf`, `out_full <= 0`.
  - Otherwise `net_so <= 0`; `net_do` holds its last value.
- Packet bit 0 is the virtual-channel bit and is compared against `net_polarity`. A packet waits while its VC bit does not match.
- Simultaneous events:
  - Injection and a write of 10 on the same edge: the write sees `out_full` = 1 (pre-edge value) and is dropped.
  - An ejection capture and a read of 00 cannot coincide, because `net_ri` = 0 while full.
  - A read of 01/11 on any edge returns the pre-edge status.
- Reset, asserted at any time including mid-handshake:
  - `in_full`, `out_full`, `net_so`, `d_out`, `net_do`, `ibuf` and `obuf` all go to 0.
  - `net_ri` = 1.
  - Any packet held in either buffer is lost.

## Timing
- Register read latency is 1 cycle: `d_out` is valid on the edge after the `nicEn` cycle, matching data memory latency. `d_out` holds between reads.
- Write latency is 1 cycle: status 11 reads 1 on the access issued in the cycle after the write.
- Ejection latency is 1 cycle: `net_ri` drops the cycle after the capture, and 01 reads 1 from that cycle on.
- Injection:
  - `net_so` rises the edge after the injection condition holds and stays high exactly 1 cycle.
  - Minimum write-to-`net_so` is 1 cycle.
- Back-to-back throughput is one packet per 2 cycles per direction:
  - output side: write, then inject;
  - input side: capture, then read.

## Structure
- Package `cardinal_nic_pkg` holds:
  - address constants `NIC_IBUF`, `NIC_ISTAT`, `NIC_OBUF`, `NIC_OSTAT`;
  - `DATA_W`;
  - packet field position `PKT_VC_BIT = 0`.
- Sub-module `nic_chan_buf`: one-entry buffer with data register, full flag, `load` and `unload` strobes. It is instantiated twice, for input and output.
- Top-level logic: address decode, the injection condition, and registered `d_out`, `net_so` and `net_do`.

## Test plan
- Reset, then poll status: read 01 and read 11 both return 0; `net_ri` = 1; `net_so` = 0.
- Output path: write 10 with `0x8000_0000_0000_00AA`, `net_ro` = 1, `net_polarity` = 0 → no send. Flip to `net_polarity` = 1 → one-cycle `net_so` with `net_do` = `0x8000_0000_0000_00AA`, then 11 reads 0.
- Output full: second write of 10 while `out_full` with `0x1234` → dropped. The first packet is still the one injected.
- Input path: `net_si` = 1 with `0x0000_0000_DEAD_BEEF` → `net_ri` = 0 next cycle and 01 reads 1. Read 00 → `d_out` = `0xDEAD_BEEF` one cycle later, `net_ri` returns to 1.
- Blocked injection: `net_ro` = 0 for 5 cycles with a matching VC bit → `net_so` stays 0. Raise `net_ro` → injection on the next edge.
- Reset mid-operation: both buffers full, assert `reset` for 1 cycle → all outputs 0, `net_ri` = 1, a subsequent read of 00 returns 0.

Source files
------------

// File: rtl/cardinal_nic_pkg.sv
// cardinal_nic shared constants.
// Register map, data width and packet field positions.
package cardinal_nic_pkg;

  localparam int DATA_W = 64;

  localparam logic [1:0] NIC_IBUF  = 2'b00;
  localparam logic [1:0] NIC_ISTAT = 2'b01;
  localparam logic [1:0] NIC_OBUF  = 2'b10;
  localparam logic [1:0] NIC_OSTAT = 2'b11;

  localparam int PKT_VC_BIT = 0;

  // Status word: flag in the last (LSB) big-endian bit.
  function automatic logic [0:DATA_W-1] status_word(
    input logic flag
  );
    status_word = {{(DATA_W-1){1'b0}}, flag};
  endfunction

endpackage

// File: rtl/nic_chan_buf.sv
// One-entry channel buffer.
// Data register plus full flag; caller gates load/unload.
module nic_chan_buf
  import cardinal_nic_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         unload,
  input  logic [0:W-1] d,
  output logic [0:W-1] q,
  output logic         full
);

  // Capture on load; clear full on unload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= '0;
      full <= 1'b0;
    end else begin
      if (load) begin
        q <= d;
      end
      if (load) begin
        full <= 1'b1;
      end else if (unload) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cardinal_nic.sv
// cardinal_nic: processor register window plus
// ring router inject/eject handshake.
module cardinal_nic
  import cardinal_nic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity
);

  logic              rd_en;
  logic              wr_en;
  logic              in_full;
  logic              out_full;
  logic              inject;
  logic              in_load;
  logic              in_unload;
  logic              out_load;
  logic [0:DATA_W-1] ibuf;
  logic [0:DATA_W-1] obuf;
  logic [0:DATA_W-1] rd_data;

  assign rd_en = nicEn & ~nicWrEn;
  assign wr_en = nicEn & nicWrEn;

  assign net_ri    = ~in_full;
  assign in_load   = net_si & ~in_full;
  assign in_unload = rd_en & (addr == NIC_IBUF)
                   & in_full;

  // Uses pre-edge out_full, so a write racing
  // an injection is dropped.
  assign out_load = wr_en & (addr == NIC_OBUF)
                  & ~out_full;
  assign inject   = out_full & net_ro
                  & (obuf[PKT_VC_BIT] == net_polarity);

  nic_chan_buf #(.W(DATA_W)) u_ibuf (
    .clk    (clk),
    .reset  (reset),
    .load   (in_load),
    .unload (in_unload),
    .d      (net_di),
    .q      (ibuf),
    .full   (in_full)
  );

  nic_chan_buf #(.W(DATA_W)) u_obuf (
    .clk    (clk),
    .reset  (reset),
    .load   (out_load),
    .unload (inject),
    .d      (d_in),
    .q      (obuf),
    .full   (out_full)
  );

  // Register read mux; output buffer reads as zero.
  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      (addr == NIC_IBUF):  rd_data = ibuf;
      (addr == NIC_ISTAT): rd_data = status_word(in_full);
      (addr == NIC_OBUF):  rd_data = '0;
      (addr == NIC_OSTAT): rd_data = status_word(out_full);
      default:             rd_data = '0;
    endcase
  end

  // Registered read data; holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_out <= '0;
    end else if (rd_en) begin
      d_out <= rd_data;
    end
  end

  // One-cycle send pulse; net_do holds last packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      net_so <= 1'b0;
      net_do <= '0;
    end else begin
      net_so <= inject;
      if (inject) begin
        net_do <= obuf;
      end
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// Self-checking bench for cardinal_nic.
// Scoreboard queues for register reads and injected packets.
module tb_cardinal_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [0:63] d_in;
  logic [0:63] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;

  int errors = 0;
  int checks = 0;

  logic [0:63] rd_q[$];
  logic [0:63] pkt_q[$];

  cardinal_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a,
                    input logic [0:63] exp,
                    input string nm);
    logic [0:63] e;
    addr    = a;
    nicEn   = 1'b1;
    nicWrEn = 1'b0;
    rd_q.push_back(exp);
    step();
    nicEn = 1'b0;
    e = rd_q.pop_front();
    checks++;
    if (d_out !== e) begin
      errors++;
      $display("FAIL %s: d_out=%h want %h", nm, d_out, e);
    end
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [0:63] d);
    addr    = a;
    d_in    = d;
    nicEn   = 1'b1;
    nicWrEn = 1'b1;
    step();
    nicEn   = 1'b0;
    nicWrEn = 1'b0;
  endtask

  task automatic chk_so(input logic exp, input string nm);
    logic [0:63] e;
    checks++;
    if (net_so !== exp) begin
      errors++;
      $display("FAIL %s: net_so=%b want %b", nm, net_so, exp);
    end
    if (exp && net_so === 1'b1) begin
      e = pkt_q.pop_front();
      checks++;
      if (net_do !== e) begin
        errors++;
        $display("FAIL %s_do: net_do=%h want %h", nm, net_do, e);
      end
    end
  endtask

  task automatic chk_ri(input logic exp, input string nm);
    checks++;
    if (net_ri !== exp) begin
      errors++;
      $display("FAIL %s: net_ri=%b want %b", nm, net_ri, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    addr = 2'b00; d_in = '0; nicEn = 0; nicWrEn = 0;
    net_si = 0; net_di = '0; net_ro = 0; net_polarity = 0;
    step(); step();
    reset = 1'b0;
    step();
    chk_ri(1'b1, "rst_ri");
    chk_so(1'b0, "rst_so");
    checks++;
    if (d_out !== 64'h0 || net_do !== 64'h0) begin
      errors++;
      $display("FAIL rst_out: d_out=%h net_do=%h want 0", d_out, net_do);
    end
    rd(2'b01, 64'h0, "rst_istat");
    rd(2'b11, 64'h0, "rst_ostat");
  endtask

  task automatic test_output();
    net_ro = 1'b1;
    net_polarity = 1'b0;
    wr(2'b10, 64'h8000_0000_0000_00AA);
    pkt_q.push_back(64'h8000_0000_0000_00AA);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_so(1'b0, "out_vc_wait");
    end
    rd(2'b11, 64'h1, "out_ostat_full");
    wr(2'b10, 64'h1234);
    chk_so(1'b0, "out_drop_wait");
    net_polarity = 1'b1;
    step();
    chk_so(1'b1, "out_send");
    step();
    chk_so(1'b0, "out_pulse_end");
    checks++;
    if (net_do !== 64'h8000_0000_0000_00AA) begin
      errors++;
      $display("FAIL out_hold: net_do=%h want 80000000000000aa", net_do);
    end
    rd(2'b11, 64'h0, "out_ostat_empty");
    rd(2'b10, 64'h0, "obuf_read_zero");
  endtask

  task automatic test_input();
    net_di = 64'h0000_0000_DEAD_BEEF;
    net_si = 1'b1;
    step();
    net_si = 1'b0;
    chk_ri(1'b0, "in_ri_low");
    rd(2'b01, 64'h1, "in_istat_full");
    rd(2'b00, 64'h0000_0000_DEAD_BEEF, "in_read");
    chk_ri(1'b1, "in_ri_back");
    rd(2'b01, 64'h0, "in_istat_empty");
    rd(2'b00, 64'h0000_0000_DEAD_BEEF, "in_stale");
    rd(2'b01, 64'h0, "in_stale_stat");
  endtask

  task automatic test_blocked();
    net_ro = 1'b0;
    net_polarity = 1'b0;
    wr(2'b10, 64'h0000_0000_0000_0055);
    pkt_q.push_back(64'h0000_0000_0000_0055);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_so(1'b0, "blk_wait");
    end
    net_ro = 1'b1;
    step();
    chk_so(1'b1, "blk_send");
    step();
    chk_so(1'b0, "blk_end");
  endtask

  task automatic test_back_to_back();
    logic [0:63] p;
    net_ro = 1'b1;
    net_polarity = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p = {1'b0, 31'(i + 7), 32'($urandom)};
      wr(2'b10, p);
      pkt_q.push_back(p);
      step();
      chk_so(1'b1, "b2b_out");
    end
    for (int i = 0; i < 3; i++) begin
      p = {32'($urandom), 32'(i)};
      net_di = p;
      net_si = 1'b1;
      step();
      net_si = 1'b0;
      chk_ri(1'b0, "b2b_in_ri");
      rd(2'b00, p, "b2b_in");
    end
  endtask

  task automatic test_reset_mid();
    net_ro = 1'b0;
    wr(2'b10, 64'h0123_4567_89AB_CDEF);
    net_di = 64'hFEED_FACE_0000_1111;
    net_si = 1'b1;
    step();
    net_si = 1'b0;
    rd(2'b11, 64'h1, "mid_ostat");
    rd(2'b01, 64'h1, "mid_istat");
    #2;
    reset = 1'b1;
    #1;
    chk_ri(1'b1, "mid_async_ri");
    step();
    reset = 1'b0;
    chk_so(1'b0, "mid_so");
    checks++;
    if (d_out !== 64'h0 || net_do !== 64'h0) begin
      errors++;
      $display("FAIL mid_out: d_out=%h net_do=%h want 0", d_out, net_do);
    end
    rd(2'b00, 64'h0, "mid_ibuf");
    rd(2'b01, 64'h0, "mid_istat0");
    rd(2'b11, 64'h0, "mid_ostat0");
  endtask

  initial begin
    test_reset();
    test_output();
    test_input();
    test_blocked();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (pkt_q.size() != 0) begin
      errors++;
      $display("FAIL pkt_left: %0d packets never sent, want 0",
               pkt_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
